serial_sub16: RTL and testbench



---
 rtl/arith_pkg.sv | 13 +
 rtl/full_adder.sv | 13 +
 rtl/serial_sub16.sv | 110 +++++++++++
 tb/tb_serial_sub16.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: operand width, counter width and serial FSM encoding.
package arith_pkg;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/full_adder.sv
// 1-bit full adder cell, shared with the ripple-carry adder chain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_sub16.sv
// Bit-serial 16-bit subtractor: D = A - B - Bi, LSB first, computed as A + ~B + ~Bi
// through one reused full adder, with a start/busy/done handshake.
module serial_sub16
  import arith_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bi,
  input  logic             start,
  output logic [WIDTH-1:0] D,
  output logic             Bo,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sa_q, sa_d;
  logic [WIDTH-1:0]   sb_q, sb_d;
  logic [WIDTH-1:0]   sd_q, sd_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   d_q, d_d;
  logic               bo_q, bo_d;
  logic               busy_q;
  logic               done_q;
  logic               fa_s;
  logic               fa_co;

  full_adder u_fa (
    .a  (sa_q[0]),
    .b  (~sb_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sd_d    = sd_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    bo_d    = bo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sa_d    = A;
          sb_d    = B;
          carry_d = ~Bi;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sa_d    = sa_q >> 1;
        sb_d    = sb_q >> 1;
        sd_d    = {fa_s, sd_q[WIDTH-1:1]};
        carry_d = fa_co;
        cnt_d   = cnt_q + CNT_W'(1);
        // Result registers load on the final bit so they are valid throughout DONE
        if (cnt_q == LAST_BIT) begin
          d_d     = {fa_s, sd_q[WIDTH-1:1]};
          bo_d    = ~fa_co;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sd_q    <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      d_q     <= '0;
      bo_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sd_q    <= sd_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      bo_q    <= bo_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
    end
  end

  assign D    = d_q;
  assign Bo   = bo_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_serial_sub16.sv
// Directed self-checking bench for serial_sub16.
module tb_serial_sub16;

  logic        clk;
  logic        rst_n;
  logic [15:0] A;
  logic [15:0] B;
  logic        Bi;
  logic        start;
  logic [15:0] D;
  logic        Bo;
  logic        busy;
  logic        done;

  int checks = 0;
  int passed = 0;

  serial_sub16 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .B     (B),
    .Bi    (Bi),
    .start (start),
    .D     (D),
    .Bo    (Bo),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Wait for IDLE, present operands with start for one rising edge; returns #1 after that edge.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic bi);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    A = a; B = b; Bi = bi; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count rising edges until done is seen (sampled #1 after each edge), bounded.
  task automatic wait_done(output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    while (cyc < 40 && !ok) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; A = '0; B = '0; Bi = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (D !== 16'h0)  $display("FAIL reset_D got=%h exp=0000", D);  else passed++;
    checks++; if (Bo !== 1'b0)  $display("FAIL reset_Bo got=%b exp=0", Bo);   else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int n_busy, n_done, done_at;
    logic [15:0] d_cap;
    logic        bo_cap;
    n_done = 0; done_at = -1; d_cap = 'x; bo_cap = 1'bx;
    start_op(16'd5, 16'd3, 1'b0);
    n_busy = busy ? 1 : 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (busy) n_busy++;
      if (done) begin n_done++; done_at = c; d_cap = D; bo_cap = Bo; end
    end
    checks++; if (n_busy !== 17)  $display("FAIL basic_busy_cycles got=%0d exp=17", n_busy);  else passed++;
    checks++; if (n_done !== 1)   $display("FAIL basic_done_pulses got=%0d exp=1", n_done);   else passed++;
    checks++; if (done_at !== 16) $display("FAIL basic_latency got=%0d exp=16", done_at);     else passed++;
    checks++; if (d_cap !== 16'd2) $display("FAIL basic_D got=%h exp=0002", d_cap);           else passed++;
    checks++; if (bo_cap !== 1'b0) $display("FAIL basic_Bo got=%b exp=0", bo_cap);           else passed++;
  endtask

  task automatic test_vectors();
    logic [15:0] va [4];
    logic [15:0] vb [4];
    logic        vbi[4];
    logic [15:0] ed [4];
    logic        ebo[4];
    int cyc;
    bit ok;
    va[0] = 16'h0000; vb[0] = 16'h0001; vbi[0] = 1'b0; ed[0] = 16'hFFFF; ebo[0] = 1'b1;
    va[1] = 16'hFFFF; vb[1] = 16'h0000; vbi[1] = 1'b1; ed[1] = 16'hFFFE; ebo[1] = 1'b0;
    va[2] = 16'h0000; vb[2] = 16'hFFFF; vbi[2] = 1'b1; ed[2] = 16'h0000; ebo[2] = 1'b1;
    va[3] = 16'h8000; vb[3] = 16'h8000; vbi[3] = 1'b0; ed[3] = 16'h0000; ebo[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      start_op(va[i], vb[i], vbi[i]);
      wait_done(cyc, ok);
      checks++;
      if (!ok || D !== ed[i]) $display("FAIL vec%0d_D got=%h exp=%h done_seen=%0d", i, D, ed[i], ok);
      else passed++;
      checks++;
      if (!ok || Bo !== ebo[i]) $display("FAIL vec%0d_Bo got=%b exp=%b done_seen=%0d", i, Bo, ebo[i], ok);
      else passed++;
    end
  endtask

  task automatic test_ignored_start();
    int n_done;
    logic [15:0] d_cap;
    logic        bo_cap;
    n_done = 0; d_cap = 'x; bo_cap = 1'bx;
    start_op(16'd1000, 16'd1, 1'b0);
    for (int c = 1; c <= 25; c++) begin
      @(posedge clk);
      #1;
      if (done) begin n_done++; d_cap = D; bo_cap = Bo; end
      if (c == 3) begin A = 16'd7; B = 16'd9; Bi = 1'b1; start = 1'b1; end
      else if (c == 16) start = 1'b1;
      else start = 1'b0;
    end
    checks++; if (n_done !== 1)       $display("FAIL ignore_done_pulses got=%0d exp=1", n_done); else passed++;
    checks++; if (d_cap !== 16'd999)  $display("FAIL ignore_D got=%h exp=03e7", d_cap);         else passed++;
    checks++; if (bo_cap !== 1'b0)    $display("FAIL ignore_Bo got=%b exp=0", bo_cap);           else passed++;
    checks++; if (busy !== 1'b0)      $display("FAIL ignore_idle_after got=%b exp=0", busy);     else passed++;
  endtask

  task automatic test_reset_mid();
    int n_done, cyc;
    bit ok;
    n_done = 0;
    start_op(16'd50, 16'd20, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy got=%b exp=0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL rstmid_done got=%b exp=0", done); else passed++;
    checks++; if (D !== 16'h0)   $display("FAIL rstmid_D got=%h exp=0000", D);    else passed++;
    checks++; if (Bo !== 1'b0)   $display("FAIL rstmid_Bo got=%b exp=0", Bo);     else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (done) n_done++;
    end
    checks++; if (n_done !== 0) $display("FAIL rstmid_no_done got=%0d exp=0", n_done); else passed++;
    start_op(16'd100, 16'd35, 1'b1);
    wait_done(cyc, ok);
    checks++; if (!ok || D !== 16'd64) $display("FAIL rstmid_next_D got=%h exp=0040 done_seen=%0d", D, ok); else passed++;
    checks++; if (!ok || Bo !== 1'b0)  $display("FAIL rstmid_next_Bo got=%b exp=0 done_seen=%0d", Bo, ok); else passed++;
  endtask

  task automatic test_back_to_back();
    int cyc, n;
    bit ok;
    n = 0;
    @(negedge clk);
    while (busy && n < 50) begin @(negedge clk); n++; end
    A = 16'd10; B = 16'd3; Bi = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    A = 16'd20; B = 16'd5; Bi = 1'b1;
    wait_done(cyc, ok);
    checks++; if (!ok || cyc !== 16) $display("FAIL b2b_lat1 got=%0d exp=16 done_seen=%0d", cyc, ok); else passed++;
    checks++; if (!ok || D !== 16'd7) $display("FAIL b2b_D1 got=%h exp=0007", D);                      else passed++;
    wait_done(cyc, ok);
    start = 1'b0;
    checks++; if (!ok || cyc !== 18)  $display("FAIL b2b_lat2 got=%0d exp=18 done_seen=%0d", cyc, ok); else passed++;
    checks++; if (!ok || D !== 16'd14) $display("FAIL b2b_D2 got=%h exp=000e", D);                     else passed++;
    checks++; if (!ok || Bo !== 1'b0)  $display("FAIL b2b_Bo2 got=%b exp=0", Bo);                      else passed++;
  endtask

  task automatic test_sweep();
    logic [16:0] ref_full;
    logic [15:0] a, b;
    logic        bi;
    int cyc;
    bit ok;
    for (int i = 0; i < 16; i++) begin
      a  = 16'(i + 35);
      b  = 16'(i);
      bi = ((i % 4) != 0);
      ref_full = {1'b0, a} - {1'b0, b} - {16'b0, bi};
      start_op(a, b, bi);
      wait_done(cyc, ok);
      checks++;
      if (!ok || D !== ref_full[15:0]) $display("FAIL sweep%0d_D got=%h exp=%h done_seen=%0d", i, D, ref_full[15:0], ok);
      else passed++;
      checks++;
      if (!ok || Bo !== ref_full[16]) $display("FAIL sweep%0d_Bo got=%b exp=%b done_seen=%0d", i, Bo, ref_full[16], ok);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
    test_sweep();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
